// File: rtl/saradc_sar_ctrl_if.sv
// Host/comparator-side signal bundle for the SAR sequencer.
// master: the sequencer itself; slave: host plus comparator/logic-buffer side.
interface saradc_sar_ctrl_if #(
    parameter int unsigned NBITS = 8
);
    logic             start;
    logic             cmpp;
    logic             cmpn;
    logic             sample;
    logic             valid;
    logic [NBITS-1:1] resultp;
    logic [NBITS-1:1] resultn;
    logic             busy;
    logic [NBITS-1:0] dout;
    logic             drdy;
    logic             err;

    modport master (
        input  start, cmpp, cmpn,
        output sample, valid, resultp, resultn, busy, dout, drdy, err
    );

    modport slave (
        output start, cmpp, cmpn,
        input  sample, valid, resultp, resultn, busy, dout, drdy, err
    );
endinterface

// File: rtl/saradc_sar_ctrl.sv
// Successive-approximation sequencer: IDLE -> SMP -> CONV -> IDLE.
// Holds SAMPLE for SAMPLE_CYCLES clocks, then takes NBITS comparator
// decisions MSB first, driving the per-bit DAC legs and publishing the code
// with a one-cycle drdy strobe.
// Optional feature macro: SARADC_CTRL_CMPERR_EN (comparator fault detection
// and sticky err output). Without it, err is tied low and cmpn is ignored.
module saradc_sar_ctrl #(
    parameter int unsigned NBITS         = 8,
    parameter int unsigned SAMPLE_CYCLES = 2
) (
    input logic               clk,
    input logic               rst,
    saradc_sar_ctrl_if.master bus
);
    localparam int unsigned KW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [KW-1:0] KMAX     = KW'(NBITS - 1);
    localparam logic [7:0]    SMP_LOAD = 8'(SAMPLE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSmp, StConv} state_e;

    state_e           state_q;
    logic [7:0]       cnt_q;
    logic [KW-1:0]    k_q;
    logic             sample_q;
    logic             valid_q;
    logic [NBITS-1:1] resultp_q;
    logic [NBITS-1:1] resultn_q;
    logic             busy_q;
    logic [NBITS-1:0] dout_q;
    logic             drdy_q;
    logic             d;

`ifdef SARADC_CTRL_CMPERR_EN
    logic fault;
    logic err_q;

    // An unresolved (or doubly-high) comparator is a fault; the bit is forced to 0.
    always_comb begin
        fault = (bus.cmpp == bus.cmpn);
        d     = bus.cmpp & ~fault;
    end

    // Sticky fault flag, cleared at each accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == StIdle && bus.start) begin
            err_q <= 1'b0;
        end else if (state_q == StConv && fault) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    logic unused_cmpn;

    // Decision comes straight from the P-side comparator output.
    always_comb begin
        d = bus.cmpp;
    end

    assign unused_cmpn = bus.cmpn;
    assign bus.err     = 1'b0;
`endif

    // Main sequencer: state, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            k_q       <= '0;
            sample_q  <= 1'b0;
            valid_q   <= 1'b1;
            resultp_q <= '0;
            resultn_q <= '0;
            busy_q    <= 1'b0;
            dout_q    <= '0;
            drdy_q    <= 1'b0;
        end else begin
            drdy_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q   <= StSmp;
                        cnt_q     <= SMP_LOAD;
                        sample_q  <= 1'b1;
                        busy_q    <= 1'b1;
                        resultp_q <= '0;
                        resultn_q <= '0;
                    end
                end
                StSmp: begin
                    if (cnt_q == 8'd0) begin
                        state_q  <= StConv;
                        sample_q <= 1'b0;
                        valid_q  <= 1'b0;
                        k_q      <= KMAX;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                StConv: begin
                    if (k_q != '0) begin
                        resultp_q[k_q] <= d;
                        resultn_q[k_q] <= ~d;
                        k_q            <= k_q - 1'b1;
                    end else begin
                        // LSB decision goes only into the published code.
                        dout_q  <= {resultp_q, d};
                        valid_q <= 1'b1;
                        drdy_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.sample  = sample_q;
    assign bus.valid   = valid_q;
    assign bus.resultp = resultp_q;
    assign bus.resultn = resultn_q;
    assign bus.busy    = busy_q;
    assign bus.dout    = dout_q;
    assign bus.drdy    = drdy_q;
endmodule

// File: tb/tb_saradc_sar_ctrl.sv
// Self-checking bench for saradc_sar_ctrl (NBITS=8, SAMPLE_CYCLES=2).
// A comparator model feeds queued codes MSB first; expected codes go into a
// scoreboard queue and are popped whenever drdy is seen.
module tb_saradc_sar_ctrl;
    logic clk = 1'b0;
    logic rst;

    saradc_sar_ctrl_if #(.NBITS(8)) bus ();

    saradc_sar_ctrl #(
        .NBITS         (8),
        .SAMPLE_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         tests_run    = 0;
    int         tests_failed = 0;
    logic [7:0] exp_q[$];
    logic [7:0] cmp_q[$];
    int         fault_bit    = -1;

    // Comparator model: presents one bit per CONV cycle during clk low.
    logic       cmp_active = 1'b0;
    int         cmp_idx    = 7;
    logic [7:0] cmp_cur    = 8'h00;
    always @(negedge clk) begin
        if (bus.valid === 1'b0) begin
            if (!cmp_active) begin
                cmp_active = 1'b1;
                cmp_idx    = 7;
                if (cmp_q.size() > 0) cmp_cur = cmp_q.pop_front();
                else cmp_cur = 8'h00;
            end
            if (cmp_idx == fault_bit) begin
                bus.cmpp = 1'b1;
                bus.cmpn = 1'b1;
            end else begin
                bus.cmpp = cmp_cur[cmp_idx];
                bus.cmpn = ~cmp_cur[cmp_idx];
            end
            if (cmp_idx > 0) cmp_idx--;
        end else begin
            cmp_active = 1'b0;
            bus.cmpp   = 1'b0;
            bus.cmpn   = 1'b1;
        end
    end

    // Advance one clock, sample #1 later, and score any drdy strobe.
    task automatic tick();
        logic [7:0] e;
        @(posedge clk);
        #1;
        if (bus.drdy === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_unexpected_drdy: dout=%h, no conversion expected", bus.dout);
            end else begin
                e = exp_q.pop_front();
                if (bus.dout !== e) begin
                    tests_failed++;
                    $display("FAIL sb_dout: got %h, expected %h", bus.dout, e);
                end
            end
        end
    endtask

    task automatic check_sb_empty(input string name);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_missing_drdy: %0d pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({bus.sample, bus.valid, bus.busy, bus.drdy, bus.err} !== 5'b01000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got s/v/b/d/e=%b, expected 01000",
                     {bus.sample, bus.valid, bus.busy, bus.drdy, bus.err});
        end
        tests_run++;
        if (bus.resultp !== 7'h00 || bus.resultn !== 7'h00 || bus.dout !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_data: got rp=%h rn=%h dout=%h, expected 00 00 00",
                     bus.resultp, bus.resultn, bus.dout);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_nominal();
        cmp_q.push_back(8'hA5);
        exp_q.push_back(8'hA5);
        bus.start = 1'b1;
        tick();                       // T0
        bus.start = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            tests_run++;
            if (bus.sample !== (i < 2) || bus.valid !== !(i >= 2 && i < 10)
                || bus.busy !== (i < 10) || bus.drdy !== (i == 10)) begin
                tests_failed++;
                $display("FAIL nominal_timing T0+%0d: got s/v/b/d=%b%b%b%b, expected %b%b%b%b",
                         i, bus.sample, bus.valid, bus.busy, bus.drdy,
                         (i < 2), !(i >= 2 && i < 10), (i < 10), (i == 10));
            end
            if (i == 5) begin
                tests_run++;
                if (bus.resultp !== 7'b1010000 || bus.resultn !== 7'b0100000) begin
                    tests_failed++;
                    $display("FAIL nominal_partial: got rp=%b rn=%b, expected 1010000 0100000",
                             bus.resultp, bus.resultn);
                end
            end
            if (i < 10) tick();
        end
        tests_run++;
        if (bus.dout !== 8'hA5 || bus.resultp !== 7'b1010010 || bus.resultn !== 7'b0101101
            || bus.err !== 1'b0) begin
            tests_failed++;
            $display("FAIL nominal_result: got dout=%h rp=%b rn=%b err=%b, expected a5 1010010 0101101 0",
                     bus.dout, bus.resultp, bus.resultn, bus.err);
        end
        tick();
        tests_run++;
        if (bus.drdy !== 1'b0 || bus.resultp !== 7'b1010010) begin
            tests_failed++;
            $display("FAIL nominal_hold: got drdy=%b rp=%b, expected 0 1010010",
                     bus.drdy, bus.resultp);
        end
        check_sb_empty("nominal");
    endtask

    task automatic test_back_to_back();
        int first  = -1;
        int second = -1;
        cmp_q.push_back(8'h00);
        cmp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        bus.start = 1'b1;
        tick();                       // T0
        for (int i = 1; i <= 30; i++) begin
            if (i == 12) bus.start = 1'b0;
            tick();
            if (bus.drdy === 1'b1) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
            if (i == 11) begin
                tests_run++;
                if (bus.sample !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL b2b_resample: got sample=%b, expected 1", bus.sample);
                end
            end
        end
        tests_run++;
        if (first != 10 || second != 21) begin
            tests_failed++;
            $display("FAIL b2b_drdy_cycles: got %0d,%0d, expected 10,21", first, second);
        end
        check_sb_empty("b2b");
    endtask

    task automatic test_ignored_start();
        int n_drdy = 0;
        int at     = -1;
        cmp_q.push_back(8'h3C);
        exp_q.push_back(8'h3C);
        bus.start = 1'b1;
        tick();                       // T0
        for (int i = 1; i <= 16; i++) begin
            bus.start = (i == 4 || i == 9);
            tick();
            if (bus.drdy === 1'b1) begin
                n_drdy++;
                at = i;
            end
            if (i >= 2) begin
                tests_run++;
                if (bus.sample !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL ignstart_sample T0+%0d: got %b, expected 0", i, bus.sample);
                end
            end
        end
        bus.start = 1'b0;
        tests_run++;
        if (n_drdy != 1 || at != 10) begin
            tests_failed++;
            $display("FAIL ignstart_drdy: got %0d strobes at %0d, expected 1 at 10", n_drdy, at);
        end
        check_sb_empty("ignstart");
    endtask

    task automatic test_reset_mid();
        int at = -1;
        cmp_q.push_back(8'h77);       // aborted, never published
        bus.start = 1'b1;
        tick();                       // T0
        bus.start = 1'b0;
        for (int i = 1; i <= 5; i++) tick();
        rst = 1'b1;
        tick();                       // T0+6
        rst = 1'b0;
        tests_run++;
        if (bus.valid !== 1'b1 || bus.resultp !== 7'h00 || bus.resultn !== 7'h00
            || bus.busy !== 1'b0 || bus.sample !== 1'b0 || bus.drdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_state: got v=%b rp=%h rn=%h b=%b s=%b d=%b, expected 1 00 00 0 0 0",
                     bus.valid, bus.resultp, bus.resultn, bus.busy, bus.sample, bus.drdy);
        end
        for (int i = 0; i < 12; i++) tick(); // any drdy here is flagged by the scoreboard
        cmp_q.push_back(8'h5A);
        exp_q.push_back(8'h5A);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.drdy === 1'b1 && at < 0) at = i;
        end
        tests_run++;
        if (at != 10) begin
            tests_failed++;
            $display("FAIL rstmid_recover: got drdy at %0d, expected 10", at);
        end
        check_sb_empty("rstmid");
    endtask

`ifdef SARADC_CTRL_CMPERR_EN
    task automatic test_fault();
        cmp_q.push_back(8'hFF);
        exp_q.push_back(8'hDF);
        fault_bit = 5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i <= 10; i++) tick();
        fault_bit = -1;
        tests_run++;
        if (bus.err !== 1'b1 || bus.dout !== 8'hDF || bus.resultp !== 7'b1101111
            || bus.resultn !== 7'b0010000) begin
            tests_failed++;
            $display("FAIL fault_result: got err=%b dout=%h rp=%b rn=%b, expected 1 df 1101111 0010000",
                     bus.err, bus.dout, bus.resultp, bus.resultn);
        end
        tick();
        tick();
        tests_run++;
        if (bus.err !== 1'b1) begin
            tests_failed++;
            $display("FAIL fault_sticky: got err=%b, expected 1", bus.err);
        end
        cmp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tests_run++;
        if (bus.err !== 1'b0) begin
            tests_failed++;
            $display("FAIL fault_clear: got err=%b, expected 0", bus.err);
        end
        for (int i = 1; i <= 12; i++) tick();
        check_sb_empty("fault");
    endtask
`endif

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        test_reset();
        test_nominal();
        test_back_to_back();
        test_ignored_start();
        test_reset_mid();
`ifdef SARADC_CTRL_CMPERR_EN
        test_fault();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
